spi_dac_multi_writer: RTL and testbench

Parametrised multi-channel SPI writer for the 4-channel, 32-bit-frame serial DAC on the sequence-decomposer board. On one `start` request it latches one sample per enabled channel and sends one SPI frame per channel in ascending channel order. It supports programmable SCK rate, configurable data width, and two update modes: per-channel immediate update, or simultaneous update of all channels. It checks the DAC's SDO echo against the previously sent frame and sits between the decomposer output stage and the DAC pins.

---
 rtl/dac_spi_pkg.sv | 39 +++
 rtl/spi_dac_shifter.sv | 123 ++++++++++++
 rtl/spi_dac_multi_writer.sv | 164 ++++++++++++++++
 tb/tb_spi_dac_multi_writer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
`default_nettype none
// ============================================================================
// dac_spi_pkg : command codes, FSM states and frame assembly for the DAC writer
// Revision    : 1.0
// ============================================================================
package dac_spi_pkg;

  localparam int FRAME_W = 32;

  localparam logic [3:0] CMD_WR         = 4'b0000;
  localparam logic [3:0] CMD_UPD        = 4'b0001;
  localparam logic [3:0] CMD_WR_UPD_ALL = 4'b0010;
  localparam logic [3:0] CMD_WR_UPD     = 4'b0011;
  localparam logic [3:0] CMD_NOP        = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  typedef enum logic [2:0] {
    SH_IDLE    = 3'd0,
    SH_SCK_LO  = 3'd1,
    SH_SCK_HI  = 3'd2,
    SH_CS_HOLD = 3'd3,
    SH_GAP     = 3'd4
  } shf_state_t;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                     input logic [3:0]  addr,
                                                     input logic [15:0] data16);
    return {8'h00, cmd, addr, data16};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_dac_shifter.sv
`default_nettype none
// ============================================================================
// spi_dac_shifter : one 32-bit SPI frame, MSB first, with SCK divider and SDO capture
// Revision        : 1.0
// ============================================================================
module spi_dac_shifter
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               dacclk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               i_miso,
  output logic               o_cs,
  output logic               o_sck,
  output logic               o_mosi,
  output logic               o_rx_valid,
  output logic [FRAME_W-1:0] o_rx,
  output logic               o_frame_done
);

  localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

  shf_state_t           r_state;
  logic [c_div_w-1:0]   r_div;
  logic [4:0]           r_bit;
  logic [FRAME_W-2:0]   r_sr;
  logic [FRAME_W-1:0]   r_rx;
  logic                 r_rx_valid;
  logic                 r_cs;
  logic                 r_sck;
  logic                 r_mosi;
  logic                 w_div_end;

  assign w_div_end    = (r_div == c_div_last);
  assign o_cs         = r_cs;
  assign o_sck        = r_sck;
  assign o_mosi       = r_mosi;
  assign o_rx         = r_rx;
  assign o_rx_valid   = r_rx_valid;
  assign o_frame_done = (r_state == SH_GAP) && w_div_end;

  always_ff @(posedge dacclk or posedge reset) begin
    if (reset) begin
      r_state    <= SH_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_sr       <= '0;
      r_rx       <= '0;
      r_rx_valid <= 1'b0;
      r_cs       <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        SH_IDLE: begin
          if (i_load) begin
            r_sr    <= i_frame[FRAME_W-2:0];
            r_bit   <= 5'd31;
            r_div   <= '0;
            r_cs    <= 1'b0;
            r_mosi  <= i_frame[FRAME_W-1];
            r_state <= SH_SCK_LO;
          end
        end
        SH_SCK_LO: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_sck   <= 1'b1;
            r_state <= SH_SCK_HI;
          end else begin
            r_div <= r_div + c_div_one;
          end
        end
        SH_SCK_HI: begin
          if (r_div == '0) r_rx <= {r_rx[FRAME_W-2:0], i_miso};
          if (w_div_end) begin
            r_div <= '0;
            r_sck <= 1'b0;
            if (r_bit == 5'd0) begin
              r_mosi     <= 1'b0;
              r_rx_valid <= 1'b1;
              r_state    <= SH_CS_HOLD;
            end else begin
              // MOSI moves only on the falling SCK edge, so it is stable for a full low phase
              r_bit   <= r_bit - 5'd1;
              r_mosi  <= r_sr[FRAME_W-2];
              r_sr    <= {r_sr[FRAME_W-3:0], 1'b0};
              r_state <= SH_SCK_LO;
            end
          end else begin
            r_div <= r_div + c_div_one;
          end
        end
        SH_CS_HOLD: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_cs    <= 1'b1;
            r_state <= SH_GAP;
          end else begin
            r_div <= r_div + c_div_one;
          end
        end
        SH_GAP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= SH_IDLE;
          end else begin
            r_div <= r_div + c_div_one;
          end
        end
        default: r_state <= SH_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_dac_multi_writer.sv
`default_nettype none
// ============================================================================
// spi_dac_multi_writer : sequences one SPI frame per enabled channel to the DAC
// Revision             : 1.0
// ============================================================================
module spi_dac_multi_writer
  import dac_spi_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int NUM_CH  = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                     dacclk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     sync_mode,
  output logic                     busy,
  output logic                     done,
  output logic                     rb_err,
  output logic                     dac_cs,
  output logic                     dac_sck,
  output logic                     dac_mosi,
  input  logic                     dac_miso,
  output logic                     dac_clr
);

  seq_state_t                r_state;
  logic [NUM_CH-1:0]         r_rem;
  logic [NUM_CH*DATA_W-1:0]  r_data;
  logic                      r_sync;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_rb_err;
  logic                      r_clr;
  logic                      r_chk;
  logic                      r_started;
  logic [FRAME_W-1:0]        r_cur;
  logic [FRAME_W-1:0]        r_prev;

  logic [NUM_CH-1:0]         w_pick;
  logic [3:0]                w_addr;
  logic [DATA_W-1:0]         w_sample;
  logic                      w_last;
  logic [3:0]                w_cmd;
  logic [15:0]               w_data16;
  logic [FRAME_W-1:0]        w_frame;
  logic                      w_load;
  logic                      w_rx_valid;
  logic                      w_frame_done;
  logic [FRAME_W-1:0]        w_rx;

  // Lowest remaining channel wins because the loop ends on the smallest index
  always_comb begin
    w_pick   = '0;
    w_addr   = '0;
    w_sample = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_rem[i]) begin
        w_pick   = NUM_CH'(1) << i;
        w_addr   = 4'(i);
        w_sample = r_data[i*DATA_W +: DATA_W];
      end
    end
    w_last   = ((r_rem & ~w_pick) == '0);
    w_cmd    = !r_sync ? CMD_WR_UPD : (w_last ? CMD_WR_UPD_ALL : CMD_WR);
    w_data16 = 16'(w_sample) << (16 - DATA_W);
    w_frame  = build_frame(w_cmd, w_addr, w_data16);
  end

  assign w_load = (r_state == ST_LOAD);
  assign busy   = r_busy;
  assign done   = r_done;
  assign rb_err = r_rb_err;
  assign dac_clr = r_clr;

  always_ff @(posedge dacclk or posedge reset) begin
    if (reset) r_clr <= 1'b0;
    else       r_clr <= 1'b1;
  end

  always_ff @(posedge dacclk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_data    <= '0;
      r_sync    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rb_err  <= 1'b0;
      r_chk     <= 1'b0;
      r_started <= 1'b0;
      r_cur     <= '0;
      r_prev    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rem    <= ch_mask;
            r_data   <= ch_data;
            r_sync   <= sync_mode;
            r_rb_err <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          r_started <= 1'b0;
          if (r_rem == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // SDO of this frame echoes the previous one, so only frames after the first are checked
          r_rem     <= r_rem & ~w_pick;
          r_prev    <= r_cur;
          r_cur     <= w_frame;
          r_chk     <= r_started;
          r_started <= 1'b1;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_rx_valid && r_chk && (w_rx != r_prev)) r_rb_err <= 1'b1;
          if (w_frame_done) begin
            if (r_rem == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  spi_dac_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .dacclk       (dacclk),
    .reset        (reset),
    .i_load       (w_load),
    .i_frame      (w_frame),
    .i_miso       (dac_miso),
    .o_cs         (dac_cs),
    .o_sck        (dac_sck),
    .o_mosi       (dac_mosi),
    .o_rx_valid   (w_rx_valid),
    .o_rx         (w_rx),
    .o_frame_done (w_frame_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_multi_writer.sv
`default_nettype none
// ============================================================================
// tb_spi_dac_multi_writer : vector table, random transactions and corner sequences
// Revision                : 1.0
// ============================================================================
module tb_spi_dac_multi_writer;

  localparam int DW  = 12;
  localparam int NCH = 4;
  localparam int DIV = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [NCH-1:0]   mask = '0;
  logic [NCH*DW-1:0] data = '0;
  logic             sync_mode = 1'b0;
  logic             miso = 1'b0;
  logic             busy, done, rb_err, cs, sck, mosi, clr;

  logic             start2 = 1'b0;
  logic [3:0]       mask2 = '0;
  logic [63:0]      data2 = '0;
  logic             sync2 = 1'b0;
  logic             miso2 = 1'b0;
  logic             busy2, done2, err2, cs2, sck2, mosi2, clr2;

  always #5 clk = ~clk;

  spi_dac_multi_writer #(.DATA_W(DW), .NUM_CH(NCH), .CLK_DIV(DIV)) u_dut (
    .dacclk(clk), .reset(reset), .start(start), .ch_mask(mask), .ch_data(data),
    .sync_mode(sync_mode), .busy(busy), .done(done), .rb_err(rb_err), .dac_cs(cs),
    .dac_sck(sck), .dac_mosi(mosi), .dac_miso(miso), .dac_clr(clr));

  spi_dac_multi_writer #(.DATA_W(16), .NUM_CH(4), .CLK_DIV(1)) u_dut16 (
    .dacclk(clk), .reset(reset), .start(start2), .ch_mask(mask2), .ch_data(data2),
    .sync_mode(sync2), .busy(busy2), .done(done2), .rb_err(err2), .dac_cs(cs2),
    .dac_sck(sck2), .dac_mosi(mosi2), .dac_miso(miso2), .dac_clr(clr2));

  int n_chk = 0;
  int n_fail = 0;

  // SPI pin monitor and SDO echo model
  logic [31:0] m_sh = '0;
  logic [31:0] m2_sh = '0;
  int          m_nb = 0;
  int          m_win = 0;
  logic [31:0] m_q[$];
  logic [31:0] last_frame = '0;
  logic [31:0] echo = '0;
  int          eb = 0;
  int          txf = 0;
  int          flip_f = 0;
  int          flip_b = 0;
  logic [31:0] exp_q[$];
  bit          last_rb = 1'b0;

  always @(negedge cs) begin
    m_win++;
    m_nb = 0;
    txf++;
    echo = last_frame ^ ((txf == flip_f) ? (32'h1 << flip_b) : 32'h0);
    eb   = 31;
    miso = echo[eb];
  end

  always @(negedge sck) if (!cs && eb > 0) begin
    eb--;
    miso = echo[eb];
  end

  always @(posedge sck) if (!cs) begin
    m_sh = {m_sh[30:0], mosi};
    m_nb++;
  end

  always @(posedge cs) if (m_nb == 32) begin
    m_q.push_back(m_sh);
    last_frame = m_sh;
  end

  always @(posedge sck2) if (!cs2) m2_sh = {m2_sh[30:0], mosi2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: frames listed straight from the command/addressing rules
  task automatic model(input logic [3:0] mk, input logic [47:0] d, input bit sy);
    int n;
    int k;
    logic [31:0] s;
    logic [31:0] f;
    n = 0;
    k = 0;
    exp_q.delete();
    for (int ch = 0; ch < NCH; ch++) if (mk[ch]) n++;
    for (int ch = 0; ch < NCH; ch++) begin
      if (mk[ch]) begin
        k++;
        s = 32'((d >> (ch * DW)) & 48'hFFF);
        f = (sy ? ((k == n) ? 32'h2 : 32'h0) : 32'h3) << 20;
        f = f + (ch << 16) + s * (1 << (16 - DW));
        exp_q.push_back(f);
      end
    end
  endtask

  task automatic run_txn(input logic [3:0] mk, input logic [47:0] d, input bit sy,
                         input int ff, input int fb, input bit poke);
    int  n;
    int  t_exp;
    int  t_done;
    int  ndone;
    bit  exp_err;
    model(mk, d, sy);
    n       = exp_q.size();
    t_exp   = 2 + n * (1 + 66 * DIV);
    exp_err = (ff >= 2 && ff <= n);
    @(negedge clk);
    chk("rb_err_sticky", rb_err, last_rb);
    mask = mk; data = d; sync_mode = sy; start = 1'b1;
    flip_f = ff; flip_b = fb; txf = 0; m_q.delete(); m_win = 0;
    @(posedge clk);
    t_done = 0;
    ndone  = 0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        mask = 4'($urandom); data = {16'($urandom), $urandom}; sync_mode = 1'($urandom);
        chk("busy_after_accept", busy, 1);
      end
      if (c == 3) chk("rb_err_cleared", rb_err, 0);
      if (poke && c == 40) start = 1'b1;
      if (poke && c == 41) start = 1'b0;
      if (done) begin
        ndone++;
        if (t_done == 0) t_done = c;
      end
      if (t_done != 0 && c == t_done + 1) break;
    end
    chk("done_cycle", t_done, t_exp);
    chk("done_pulses", ndone, 1);
    chk("busy_after_done", busy, 0);
    chk("frame_count", m_q.size(), n);
    chk("cs_windows", m_win, n);
    for (int i = 0; i < n && i < m_q.size(); i++) chk("frame", m_q[i], exp_q[i]);
    chk("rb_err", rb_err, exp_err);
    last_rb = exp_err;
  endtask

  typedef struct {
    logic [3:0]  mk;
    logic [47:0] d;
    bit          sy;
    int          ff;
    bit          poke;
    logic [31:0] f0;
    int          nfr;
    bit          err;
  } vec_t;

  vec_t tbl[6];
  int   cnt;
  int   t2;

  initial begin
    tbl[0] = '{4'b0001, {12'h000, 12'h000, 12'h000, 12'hABC}, 1'b0, 0, 1'b0, 32'h0030ABC0, 1, 1'b0};
    tbl[1] = '{4'b1010, {12'h456, 12'h000, 12'h123, 12'h000}, 1'b1, 2, 1'b0, 32'h00011230, 2, 1'b1};
    tbl[2] = '{4'b1111, {12'hFFF, 12'h333, 12'h222, 12'h111}, 1'b0, 0, 1'b1, 32'h00301110, 4, 1'b0};
    tbl[3] = '{4'b1111, {12'h7A5, 12'h5A5, 12'h0F0, 12'h800}, 1'b1, 1, 1'b0, 32'h00008000, 4, 1'b0};
    tbl[4] = '{4'b0100, {12'h000, 12'h001, 12'h000, 12'h000}, 1'b1, 0, 1'b0, 32'h00220010, 1, 1'b0};
    tbl[5] = '{4'b1001, {12'h009, 12'h000, 12'h000, 12'h000}, 1'b0, 2, 1'b1, 32'h00300000, 2, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 1); chk("rst_sck", sck, 0); chk("rst_mosi", mosi, 0);
    chk("rst_clr", clr, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_rb_err", rb_err, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("clr_release", clr, 1);

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].mk, tbl[i].d, tbl[i].sy, tbl[i].ff, $urandom_range(0, 31), tbl[i].poke);
      chk("tbl_nfr", m_q.size(), tbl[i].nfr);
      chk("tbl_first", (m_q.size() > 0) ? m_q[0] : 32'hDEAD_BEEF, tbl[i].f0);
      chk("tbl_err", rb_err, tbl[i].err);
    end

    for (int i = 0; i < 8; i++)
      run_txn(4'($urandom), {16'($urandom), $urandom}, 1'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 31), 1'($urandom));

    run_txn(4'b0000, 48'h123456789ABC, 1'b1, 0, 0, 1'b0);

    // Mask 0 with start held high across DONE and into the following IDLE cycle
    @(negedge clk);
    mask = 4'b0000; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("m0_done", done, 1);
    @(negedge clk);
    chk("done_cycle_start_ignored", busy, 0);
    chk("m0_done_single", done, 0);
    @(negedge clk);
    chk("idle_start_accepted", busy, 1);
    start = 1'b0;
    @(negedge clk);
    chk("m0_done_again", done, 1);
    @(negedge clk);
    chk("m0_done_low", done, 0);
    last_rb = 1'b0;

    // Reset in the middle of a frame
    @(negedge clk);
    mask = 4'b0001; data = 48'h000000000ABC; sync_mode = 1'b0; start = 1'b1; m_nb = 0;
    m_q.delete();
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400 && m_nb < 17; c++) @(negedge clk);
    chk("reached_bit17", m_nb, 17);
    reset = 1'b1;
    #1;
    chk("arst_cs", cs, 1); chk("arst_sck", sck, 0); chk("arst_mosi", mosi, 0);
    chk("arst_busy", busy, 0); chk("arst_clr", clr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || !cs) cnt++;
    end
    chk("no_done_after_reset", cnt, 0);
    chk("aborted_frame_dropped", m_q.size(), 0);
    chk("clr_after_reset", clr, 1);
    last_rb = 1'b0;
    run_txn(4'b0001, 48'h000000000ABC, 1'b0, 0, 0, 1'b0);

    // 16-bit sample width, SCK at half the clock rate
    @(negedge clk);
    mask2 = 4'b0100; data2 = {16'h0000, 16'h1234, 32'h0}; start2 = 1'b1;
    @(posedge clk);
    t2 = 0;
    for (int c = 1; c <= 200 && t2 == 0; c++) begin
      @(negedge clk);
      if (c == 1) start2 = 1'b0;
      if (done2) t2 = c;
    end
    chk("dw16_frame", m2_sh, 32'h00321234);
    chk("dw16_done_cycle", t2, 69);
    chk("dw16_cs_idle", cs2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
